mig_addr_collector: RTL and testbench

MIG_ADDR_COLLECTOR -- requirements
Module: mig_addr_collector

---
 rtl/mig_pkg.sv | 7 +
 rtl/mig_req_ring.sv | 49 ++++
 rtl/mig_addr_collector.sv | 111 +++++++++++
 tb/tb_mig_addr_collector.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mig_pkg.sv
// Shared constants for the migration address collector.
package mig_pkg;
  localparam int MIG_ADDR_SIZE = 28;
  localparam int MIG_CNT_W     = 16;
  localparam int MIG_HIST_N    = 4;
  localparam logic [MIG_ADDR_SIZE-1:0] MIG_SENTINEL = '1;
endpackage

// File: rtl/mig_req_ring.sv
// Power-of-two ring buffer holding pending migration requests; flush empties it in one cycle.
module mig_req_ring #(
  parameter  int W     = 28,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head,
  output logic [LW-1:0] level,
  output logic          empty,
  output logic          full
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wptr, rptr;
  logic                    do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= push_data;
  end
endmodule

// File: rtl/mig_addr_collector.sv
// Collects migration addresses from a CDC FIFO, drops sentinels (and duplicates when
// MIG_DEDUP_EN is defined), and queues the rest as downstream migration requests.
module mig_addr_collector
  import mig_pkg::*;
#(
  parameter  int ADDR_SIZE = MIG_ADDR_SIZE,
  parameter  int DEPTH     = 8,
  parameter  int CNT_W     = MIG_CNT_W,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 mig_cdc_fifo_valid,
  input  logic [ADDR_SIZE-1:0] mig_cdc_fifo_data_out,
  output logic                 mig_cdc_fifo_ready,
  output logic                 mig_req_valid,
  output logic [ADDR_SIZE-1:0] mig_req_addr,
  input  logic                 mig_req_ready,
  input  logic                 flush,
  output logic [CNT_W-1:0]     recv_cnt,
  output logic [CNT_W-1:0]     inv_cnt,
  output logic [CNT_W-1:0]     dup_cnt,
  output logic [LW-1:0]        q_level
);
  localparam logic [LW:0] DEPTH_L = (LW+1)'(DEPTH);

  logic                 stage_v;
  logic [ADDR_SIZE-1:0] stage_addr;
  logic                 xfer, is_sent, is_dup, push, pop, empty, full;
  logic [ADDR_SIZE-1:0] head;
  logic [LW:0]          occ;

  // Reserve a slot for the stage entry so an accepted word can always be enqueued.
  assign occ                = {1'b0, q_level} + (LW+1)'(stage_v);
  assign mig_cdc_fifo_ready = rstn && !flush && (occ < DEPTH_L);
  assign xfer               = mig_cdc_fifo_valid && mig_cdc_fifo_ready;
  assign is_sent            = (stage_addr == {ADDR_SIZE{1'b1}});
  assign push               = stage_v && !flush && !is_sent && !is_dup;
  assign pop                = mig_req_valid && mig_req_ready;
  assign mig_req_valid      = !empty;
  assign mig_req_addr       = empty ? {ADDR_SIZE{1'b1}} : head;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage_v    <= 1'b0;
      stage_addr <= '1;
    end else if (flush) begin
      stage_v    <= 1'b0;
    end else begin
      stage_v    <= xfer;
      if (xfer) stage_addr <= mig_cdc_fifo_data_out;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      recv_cnt <= '0;
      inv_cnt  <= '0;
    end else if (stage_v && !flush) begin
      if (is_sent) begin
        if (inv_cnt != '1) inv_cnt <= inv_cnt + 1'b1;
      end else if (!is_dup) begin
        if (recv_cnt != '1) recv_cnt <= recv_cnt + 1'b1;
      end
    end
  end

`ifdef MIG_DEDUP_EN
  logic [MIG_HIST_N-1:0][ADDR_SIZE-1:0] hist_a;
  logic [MIG_HIST_N-1:0]                hist_v, hit;

  for (genvar i = 0; i < MIG_HIST_N; i++) begin : g_hit
    assign hit[i] = hist_v[i] && (hist_a[i] == stage_addr);
  end
  assign is_dup = !is_sent && (|hit);

  // Newest enqueued address enters at index 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_v <= '0;
      hist_a <= '0;
    end else if (flush) begin
      hist_v <= '0;
    end else if (push) begin
      hist_a <= {hist_a[MIG_HIST_N-2:0], stage_addr};
      hist_v <= {hist_v[MIG_HIST_N-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) dup_cnt <= '0;
    else if (stage_v && !flush && is_dup && dup_cnt != '1) dup_cnt <= dup_cnt + 1'b1;
  end
`else
  assign is_dup  = 1'b0;
  assign dup_cnt = '0;
`endif

  mig_req_ring #(.W(ADDR_SIZE), .DEPTH(DEPTH)) u_ring (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (stage_addr),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .level     (q_level),
    .empty     (empty),
    .full      (full)
  );
endmodule

// File: tb/tb_mig_addr_collector.sv
// Randomized and directed bench for mig_addr_collector against a queue-based reference model.
module tb_mig_addr_collector;
  import mig_pkg::*;
  localparam int AS = 28, DEPTH = 8, CW = 4, LW = 4;
`ifdef MIG_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic          clk = 1'b0, rstn = 1'b0;
  logic          mig_cdc_fifo_valid = 1'b0, mig_cdc_fifo_ready;
  logic [AS-1:0] mig_cdc_fifo_data_out = '0;
  logic          mig_req_valid, mig_req_ready = 1'b0, flush = 1'b0;
  logic [AS-1:0] mig_req_addr;
  logic [CW-1:0] recv_cnt, inv_cnt, dup_cnt;
  logic [LW-1:0] q_level;

  mig_addr_collector #(.ADDR_SIZE(AS), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn),
    .mig_cdc_fifo_valid(mig_cdc_fifo_valid), .mig_cdc_fifo_data_out(mig_cdc_fifo_data_out),
    .mig_cdc_fifo_ready(mig_cdc_fifo_ready),
    .mig_req_valid(mig_req_valid), .mig_req_addr(mig_req_addr), .mig_req_ready(mig_req_ready),
    .flush(flush), .recv_cnt(recv_cnt), .inv_cnt(inv_cnt), .dup_cnt(dup_cnt), .q_level(q_level)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: an accepted word is classified one cycle later unless a flush intervenes.
  logic [AS-1:0] exp_q[$];
  logic [AS-1:0] hist_q[$];
  bit            pend_v;
  logic [AS-1:0] pend_a;
  int            m_recv, m_inv, m_dup, req_seen;

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic bit in_hist(input logic [AS-1:0] a);
    foreach (hist_q[k]) if (hist_q[k] == a) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete(); hist_q.delete();
      pend_v = 1'b0; m_recv = 0; m_inv = 0; m_dup = 0; req_seen = 0;
    end else begin
      chk("q_level", q_level, exp_q.size());
      chk("req_valid", mig_req_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("req_addr", mig_req_addr, exp_q[0]);
      chk("fifo_ready", mig_cdc_fifo_ready, !flush && (exp_q.size() + int'(pend_v) < DEPTH));
      chk("recv_cnt", recv_cnt, sat(m_recv));
      chk("inv_cnt", inv_cnt, sat(m_inv));
      chk("dup_cnt", dup_cnt, sat(m_dup));
      if (flush) begin
        exp_q.delete(); hist_q.delete(); pend_v = 1'b0;
      end else begin
        if (mig_req_valid && mig_req_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          req_seen++;
        end
        if (pend_v) begin
          if (pend_a == MIG_SENTINEL) m_inv++;
          else if (DEDUP && in_hist(pend_a)) m_dup++;
          else begin
            exp_q.push_back(pend_a);
            m_recv++;
            hist_q.push_back(pend_a);
            if (hist_q.size() > 4) void'(hist_q.pop_front());
          end
        end
        pend_v = mig_cdc_fifo_valid && mig_cdc_fifo_ready;
        pend_a = mig_cdc_fifo_data_out;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0; mig_cdc_fifo_valid = 1'b0; flush = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic send(input logic [AS-1:0] a);
    mig_cdc_fifo_valid = 1'b1; mig_cdc_fifo_data_out = a;
    @(negedge clk);
    chk("send_ready", mig_cdc_fifo_ready, 1'b1);
    @(posedge clk); #1;
    mig_cdc_fifo_valid = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_fifo_ready"}, mig_cdc_fifo_ready, 1'b0);
    chk({tag, "_req_valid"}, mig_req_valid, 1'b0);
    chk({tag, "_req_addr"}, mig_req_addr, 28'hFFFFFFF);
    chk({tag, "_q_level"}, q_level, 0);
    chk({tag, "_cnts"}, {recv_cnt, inv_cnt, dup_cnt}, 0);
  endtask

  initial begin
    int acc;
    bit hs;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("rst");
    @(posedge clk); #1;
    rstn = 1'b1;

    // single address: two-cycle latency from transfer to request
    mig_req_ready = 1'b1;
    while (cyc < 10) @(posedge clk);
    #1;
    send(28'h0001234);
    @(negedge clk);
    chk("lat_n1_valid", mig_req_valid, 1'b0);
    @(negedge clk);
    chk("lat_n2_valid", mig_req_valid, 1'b1);
    chk("lat_n2_addr", mig_req_addr, 28'h0001234);
    chk("lat_recv", recv_cnt, 1);

    // sentinel is dropped
    do_reset();
    send(28'hFFFFFFF);
    repeat (3) begin
      @(negedge clk);
      chk("sent_valid", mig_req_valid, 1'b0);
    end
    chk("sent_inv", inv_cnt, 1);
    chk("sent_level", q_level, 0);

    // backpressure: 9 offered, 8 queued
    do_reset();
    mig_req_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      mig_cdc_fifo_valid = 1'b1; mig_cdc_fifo_data_out = 28'h100 + AS'(acc);
      @(negedge clk);
      hs = mig_cdc_fifo_ready;
      @(posedge clk); #1;
      if (hs) acc++;
    end
    chk("bp_accepted", acc, 8);
    chk("bp_level", q_level, 8);
    @(negedge clk);
    chk("bp_ready_low", mig_cdc_fifo_ready, 1'b0);
    @(posedge clk); #1;
    mig_req_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_cycle_ready", mig_cdc_fifo_ready, 1'b0);
    @(posedge clk); #1;
    mig_req_ready = 1'b0;
    @(negedge clk);
    chk("bp_ninth_ready", mig_cdc_fifo_ready, 1'b1);
    @(posedge clk); #1;
    mig_cdc_fifo_valid = 1'b0;
    mig_req_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    // duplicate filtering
    do_reset();
    mig_req_ready = 1'b1;
    send(28'h10); send(28'h20); send(28'h10);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("dedup_reqs", req_seen, DEDUP ? 2 : 3);
    chk("dedup_cnt", dup_cnt, DEDUP ? 1 : 0);

    // flush with 5 queued and one in the stage
    do_reset();
    mig_req_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(28'h200 + AS'(i));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_level", q_level, 0);
    chk("flush_valid", mig_req_valid, 1'b0);
    chk("flush_recv", recv_cnt, 5);

    // random traffic, counters saturate
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int r;
      @(posedge clk); #1;
      r = $urandom_range(9);
      mig_cdc_fifo_valid = ($urandom_range(9) < 7);
      if (r < 1)      mig_cdc_fifo_data_out = 28'hFFFFFFF;
      else if (r < 4) mig_cdc_fifo_data_out = 28'h40 + AS'($urandom_range(5));
      else            mig_cdc_fifo_data_out = AS'($urandom);
      mig_req_ready = ($urandom_range(9) < 6);
      flush = ($urandom_range(49) == 0);
    end
    @(posedge clk); #1;
    mig_cdc_fifo_valid = 1'b0; flush = 1'b0; mig_req_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("rand_recv_sat", recv_cnt, sat(m_recv));
    chk("rand_drained", mig_req_valid, 1'b0);

    // reset in the middle of a burst
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      mig_cdc_fifo_valid = 1'b1;
      mig_cdc_fifo_data_out = AS'($urandom);
      mig_req_ready = $urandom_range(1);
      if (i == 6) begin
        #2 rstn = 1'b0;
        #1 chk_reset_outs("midrst");
      end
      if (i > 6 && i < 10) begin
        @(negedge clk);
        chk("midrst_hold_ready", mig_cdc_fifo_ready, 1'b0);
      end
      if (i == 10) rstn = 1'b1;
    end
    @(posedge clk); #1;
    mig_cdc_fifo_valid = 1'b0; mig_req_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("post_rst_level", q_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
